// File: rtl/inst_rom_boot_pkg.sv
// Shared definitions for the boot-loaded instruction ROM.
//   - Active-low reset levels, chip-enable level, zero word
//   - Instruction bus types and default memory address width
//   - Loader FSM state encodings
package inst_rom_boot_pkg;

   localparam logic RstnEnable  = 1'b0;   // reset asserted
   localparam logic RstnDisable = 1'b1;   // reset released
   localparam logic ChipEnable  = 1'b1;

   localparam int InstMemAddrW = 10;      // word-address width (1024 words)

   typedef logic [31:0] inst_bus_t;       // instruction word
   typedef logic [31:0] inst_addr_bus_t;  // byte fetch address

   localparam inst_bus_t ZeroWord = 32'h0;

   typedef enum logic [2:0] {
      LdHdrHi = 3'd0,
      LdHdrLo = 3'd1,
      LdData  = 3'd2,
      LdDone  = 3'd3,
      LdErr   = 3'd4
   } ld_state_t;

endpackage

// File: rtl/inst_rom_boot_loader_fsm.sv
// Byte-stream boot loader: parses a 16-bit big-endian word count, assembles
// big-endian 32-bit words and emits one memory write per completed word.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   ld_valid/data   incoming byte stream
//   ld_ready        registered; high while a byte can be accepted
//   we/waddr/wdata  memory write, asserted combinationally on the 4th byte
//   boot_done       image fully loaded (registered)
//   boot_err        header count exceeded memory depth (registered)
module boot_loader_fsm
   import inst_rom_boot_pkg::*;
#(
   parameter int ADDR_W = InstMemAddrW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output inst_bus_t         wdata,
   output logic              boot_done,
   output logic              boot_err
);

   // 17 bits so that a full 16-bit count can be compared against DEPTH
   localparam logic [16:0] DEPTH = 17'(2**ADDR_W);

   ld_state_t         state_q, state_d;
   logic [7:0]        cnt_hi_q, cnt_hi_d;
   logic [ADDR_W-1:0] last_q, last_d;      // count-1: index of final word
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [23:0]       word_q, word_d;      // first three bytes of current word
   logic              accept;
   logic [15:0]       count;

   assign accept = ld_valid && ld_ready;
   assign count  = {cnt_hi_q, ld_data};
   assign wdata  = {word_q, ld_data};
   assign waddr  = waddr_q;

   always_comb begin
      state_d  = state_q;
      cnt_hi_d = cnt_hi_q;
      last_d   = last_q;
      waddr_d  = waddr_q;
      bidx_d   = bidx_q;
      word_d   = word_q;
      we       = 1'b0;
      case (state_q)
         LdHdrHi: if (accept) begin
            cnt_hi_d = ld_data;
            state_d  = LdHdrLo;
         end
         LdHdrLo: if (accept) begin
            if (count == 16'd0) begin
               state_d = LdDone;
            end else if ({1'b0, count} > DEPTH) begin
               state_d = LdErr;
            end else begin
               state_d = LdData;
               waddr_d = '0;
               bidx_d  = '0;
               // count <= DEPTH here, so count-1 fits in ADDR_W bits
               last_d  = ADDR_W'(count - 16'd1);
            end
         end
         LdData: if (accept) begin
            word_d = {word_q[15:0], ld_data};
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
               we = 1'b1;
               if (waddr_q == last_q) state_d = LdDone;
               else                   waddr_d = waddr_q + 1'b1;
            end
         end
         default: ;  // LdDone / LdErr hold until reset
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RstnEnable) begin
         state_q   <= LdHdrHi;
         cnt_hi_q  <= '0;
         last_q    <= '0;
         waddr_q   <= '0;
         bidx_q    <= '0;
         word_q    <= '0;
         ld_ready  <= 1'b0;
         boot_done <= 1'b0;
         boot_err  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_hi_q  <= cnt_hi_d;
         last_q    <= last_d;
         waddr_q   <= waddr_d;
         bidx_q    <= bidx_d;
         word_q    <= word_d;
         // status flags follow the next state so they rise on the edge
         // that accepts the final (or offending) byte
         ld_ready  <= (state_d == LdHdrHi) || (state_d == LdHdrLo) ||
                      (state_d == LdData);
         boot_done <= (state_d == LdDone);
         boot_err  <= (state_d == LdErr);
      end
   end

endmodule

// File: rtl/inst_rom_boot.sv
// Instruction memory with built-in boot loader. The loader fills the array
// from a byte stream after reset; fetches return data only once boot_done.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   ce, addr            fetch enable and byte address from the core
//   inst_o              combinational instruction word (0 when gated)
//   ld_valid/data/ready loader byte handshake
//   boot_done, boot_err loader status
module inst_rom_boot
   import inst_rom_boot_pkg::*;
#(
   parameter int ADDR_W = InstMemAddrW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ce,
   input  inst_addr_bus_t addr,
   output inst_bus_t      inst_o,
   input  logic           ld_valid,
   input  logic [7:0]     ld_data,
   output logic           ld_ready,
   output logic           boot_done,
   output logic           boot_err
);

   localparam int DEPTH = 2**ADDR_W;

   // storage is intentionally not reset: contents survive a reload request
   inst_bus_t         mem [DEPTH];
   logic              we;
   logic [ADDR_W-1:0] waddr;
   inst_bus_t         wdata;

   boot_loader_fsm #(.ADDR_W(ADDR_W)) u_loader (
      .clk       (clk),
      .rst       (rst),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .boot_done (boot_done),
      .boot_err  (boot_err)
   );

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // byte offset and upper bits are dropped, so fetches alias modulo DEPTH
   logic unused_addr;
   assign unused_addr = ^{addr[1:0], addr[31:ADDR_W+2]};

   assign inst_o = (ce == ChipEnable && boot_done) ? mem[addr[ADDR_W+1:2]]
                                                   : ZeroWord;

endmodule

// File: tb/tb_inst_rom_boot.sv
module tb_inst_rom_boot;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] inst_o;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_data = '0;
   logic        ld_ready, boot_done, boot_err;

   int n_checks = 0;
   int n_fail   = 0;

   inst_rom_boot dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .addr      (addr),
      .inst_o    (inst_o),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .boot_done (boot_done),
      .boot_err  (boot_err)
   );

   always #5 clk = ~clk;

   // Tasks start and end 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      ld_valid = 1'b1;
      ld_data  = b;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (ld_ready) begin
            @(posedge clk); #1;
            ld_valid = 1'b0;
            return;
         end
      end
      ld_valid = 1'b0;
      n_checks++; n_fail++;
      $display("FAIL send_byte timeout: ld_ready=%0b required 1", ld_ready);
   endtask

   task automatic read_word(input logic [31:0] a, output logic [31:0] d);
      addr = a; ce = 1'b1; #1;
      d = inst_o;
   endtask

   task automatic do_reset();
      ld_valid = 1'b0; rst = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      n_checks++;
      if (boot_done !== 1'b0 || boot_err !== 1'b0 || ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: done=%b err=%b rdy=%b required 0 0 0", boot_done, boot_err, ld_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ld_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b required 1", ld_ready);
      end
      read_word(32'h0, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL reset_fetch: got %h required 00000000", d);
      end
   endtask

   task automatic test_load2();
      logic [7:0]  s [10] = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h10, 8'h34, 8'h02, 8'h00, 8'h20};
      logic [31:0] d;
      for (int i = 0; i < 9; i++) send_byte(s[i]);
      n_checks++;
      if (boot_done !== 1'b0) begin
         n_fail++; $display("FAIL load2_early_done: got %b required 0", boot_done);
      end
      send_byte(s[9]);
      n_checks++;
      if (boot_done !== 1'b1 || ld_ready !== 1'b0) begin
         n_fail++; $display("FAIL load2_done_edge: done=%b rdy=%b required 1 0", boot_done, ld_ready);
      end
      read_word(32'h0, d);
      n_checks++;
      if (d !== 32'h34010010) begin n_fail++; $display("FAIL load2_w0: got %h required 34010010", d); end
      read_word(32'h4, d);
      n_checks++;
      if (d !== 32'h34020020) begin n_fail++; $display("FAIL load2_w1: got %h required 34020020", d); end
      read_word(32'h6, d);
      n_checks++;
      if (d !== 32'h34020020) begin n_fail++; $display("FAIL load2_lowbits: got %h required 34020020", d); end
   endtask

   task automatic test_fetch_gating();
      logic [31:0] d;
      read_word(32'h1000, d);
      n_checks++;
      if (d !== 32'h34010010) begin n_fail++; $display("FAIL gate_wrap: got %h required 34010010", d); end
      ce = 1'b0; addr = 32'h4; #1;
      n_checks++;
      if (inst_o !== 32'h0) begin n_fail++; $display("FAIL gate_ce0: got %h required 00000000", inst_o); end
      // memory holds a valid image, but a new load has not completed
      do_reset();
      @(posedge clk); #1;
      read_word(32'h4, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL gate_not_done: got %h required 00000000", d); end
   endtask

   task automatic test_reset_midload();
      logic [7:0]  s [7] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [7:0]  r [6] = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      logic [31:0] d;
      for (int i = 0; i < 7; i++) send_byte(s[i]);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      n_checks++;
      if (boot_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b required 0", boot_done); end
      @(posedge clk); #1;
      n_checks++;
      if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", ld_ready); end
      for (int i = 0; i < 6; i++) send_byte(r[i]);
      n_checks++;
      if (boot_done !== 1'b1) begin n_fail++; $display("FAIL midrst_reload_done: got %b required 1", boot_done); end
      read_word(32'h0, d);
      n_checks++;
      if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL midrst_w0: got %h required deadbeef", d); end
      // reset pulse entirely between edges
      @(negedge clk);
      rst = 1'b0; #2; rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      read_word(32'h0, d);
      n_checks++;
      if (boot_done !== 1'b1 || d !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL glitch: done=%b data=%h required 1 deadbeef", boot_done, d);
      end
   endtask

   task automatic test_stalled();
      logic [7:0]  s [10] = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h10, 8'h34, 8'h02, 8'h00, 8'h20};
      logic [31:0] d;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
         if (i == 9) begin
            n_checks++;
            if (boot_done !== 1'b0) begin n_fail++; $display("FAIL stall_early_done: got %b required 0", boot_done); end
         end
         send_byte(s[i]);
      end
      n_checks++;
      if (boot_done !== 1'b1 || ld_ready !== 1'b0) begin
         n_fail++; $display("FAIL stall_done_edge: done=%b rdy=%b required 1 0", boot_done, ld_ready);
      end
      read_word(32'h0, d);
      n_checks++;
      if (d !== 32'h34010010) begin n_fail++; $display("FAIL stall_w0: got %h required 34010010", d); end
      read_word(32'h4, d);
      n_checks++;
      if (d !== 32'h34020020) begin n_fail++; $display("FAIL stall_w1: got %h required 34020020", d); end
   endtask

   task automatic test_header_bounds();
      logic [31:0] w, d;
      // zero count
      do_reset();
      send_byte(8'h00);
      n_checks++;
      if (boot_done !== 1'b0) begin n_fail++; $display("FAIL hdr0_early: got %b required 0", boot_done); end
      send_byte(8'h00);
      n_checks++;
      if (boot_done !== 1'b1 || boot_err !== 1'b0) begin
         n_fail++; $display("FAIL hdr0_done: done=%b err=%b required 1 0", boot_done, boot_err);
      end
      // count 1025 > DEPTH
      do_reset();
      send_byte(8'h04);
      send_byte(8'h01);
      n_checks++;
      if (boot_err !== 1'b1 || ld_ready !== 1'b0 || boot_done !== 1'b0) begin
         n_fail++; $display("FAIL hdr_over: err=%b rdy=%b done=%b required 1 0 0", boot_err, ld_ready, boot_done);
      end
      ld_valid = 1'b1; ld_data = 8'h5A;
      repeat (6) begin @(posedge clk); #1; end
      ld_valid = 1'b0;
      n_checks++;
      if (boot_err !== 1'b1 || ld_ready !== 1'b0 || boot_done !== 1'b0) begin
         n_fail++; $display("FAIL hdr_over_hold: err=%b rdy=%b done=%b required 1 0 0", boot_err, ld_ready, boot_done);
      end
      // count == DEPTH fills the whole array
      do_reset();
      send_byte(8'h04);
      send_byte(8'h00);
      n_checks++;
      if (boot_err !== 1'b0) begin n_fail++; $display("FAIL hdr_full_err: got %b required 0", boot_err); end
      for (int i = 0; i < 1024; i++) begin
         w = 32'hC0DE0000 + i;
         send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]);
         if (i == 1023) begin
            n_checks++;
            if (boot_done !== 1'b0) begin n_fail++; $display("FAIL full_early_done: got %b required 0", boot_done); end
         end
         send_byte(w[7:0]);
      end
      n_checks++;
      if (boot_done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b required 1", boot_done); end
      read_word(32'hFFC, d);
      n_checks++;
      if (d !== 32'hC0DE03FF) begin n_fail++; $display("FAIL full_last: got %h required c0de03ff", d); end
      read_word(32'h800, d);
      n_checks++;
      if (d !== 32'hC0DE0200) begin n_fail++; $display("FAIL full_mid: got %h required c0de0200", d); end
   endtask

   task automatic test_post_done();
      logic [31:0] d;
      int bad_rdy = 0;
      ld_valid = 1'b1; ld_data = 8'hFF;
      repeat (10) begin
         @(negedge clk);
         if (ld_ready !== 1'b0) bad_rdy++;
         @(posedge clk); #1;
      end
      ld_valid = 1'b0;
      n_checks++;
      if (bad_rdy != 0) begin n_fail++; $display("FAIL post_ready: %0d cycles ready, required 0", bad_rdy); end
      read_word(32'hFFC, d);
      n_checks++;
      if (d !== 32'hC0DE03FF) begin n_fail++; $display("FAIL post_last: got %h required c0de03ff", d); end
      read_word(32'h0, d);
      n_checks++;
      if (d !== 32'hC0DE0000 || boot_done !== 1'b1) begin
         n_fail++; $display("FAIL post_w0: data=%h done=%b required c0de0000 1", d, boot_done);
      end
   endtask

   initial begin
      test_reset();
      test_load2();
      test_fetch_gating();
      test_reset_midload();
      test_stalled();
      test_header_bounds();
      test_post_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_rom_boot.md
Name: inst_rom_boot

Overview:
Instruction memory feeding the core's fetch port (rom_addr_o/rom_ce_o in, rom_data_i out), with a built-in boot loader. After reset, a byte-stream loader fills the memory from an external source, such as a UART receiver. It then asserts boot_done, which the SOPC uses to release the core's reset. Fetch reads are combinational, so the core's existing single-cycle fetch timing into if_id is unchanged.

Parameters:
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words (default 1024 words = 4 KiB)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
ce  in  1  fetch enable, from core rom_ce_o
addr  in  32  byte fetch address, from core rom_addr_o
inst_o  out  32  instruction word, to core rom_data_i
ld_valid  in  1  loader byte valid
ld_data  in  8  loader byte
ld_ready  out  1  loader can accept a byte
boot_done  out  1  image fully loaded; fetches enabled
boot_err  out  1  header word count exceeds DEPTH

Behaviour:
- Reset: rst is sampled at the rising clock edge while low. On reset:
  - state=HDR_HI; boot_done=0; boot_err=0; ld_ready=1 once rst is high.
  - Byte and word counters cleared; any partial word is discarded.
  - Memory array is NOT reset and keeps its prior contents.
- Fetch path (combinational):
  - inst_o = (ce==1 && boot_done==1) ? mem[addr[ADDR_W+1:2]] : 32'h0.
  - addr[1:0] is ignored. Upper address bits are ignored, so addresses alias/wrap modulo DEPTH words.
- Byte handshake: a byte is transferred on a rising edge where ld_valid && ld_ready. ld_data is ignored otherwise.
- ld_ready is registered: 1 in HDR_HI, HDR_LO and DATA; 0 in DONE, ERR and during reset.
- Stream format: 16-bit word count N, big-endian (2 bytes), followed by 4*N image bytes. Each word is big-endian: the first byte goes to [31:24].
- FSM:
  - HDR_HI: accept byte -> cnt[15:8]; go to HDR_LO.
  - HDR_LO: accept byte -> cnt[7:0]; then decide on the full count {cnt_hi, byte}:
    - count==0 -> DONE.
    - count>DEPTH -> ERR.
    - otherwise -> DATA, with waddr=0 and bidx=0.
  - DATA: accept byte -> shift into the word register; bidx++ (2-bit counter).
    - On the 4th byte (bidx==3), write mem[waddr] <= {b0,b1,b2,b3} at that same edge; bidx wraps to 0.
    - If waddr==count-1, go to DONE; otherwise waddr++.
  - DONE: boot_done=1, ld_ready=0. Stays here until reset; further ld_valid is ignored.
  - ERR: boot_err=1, ld_ready=0, boot_done=0. Stays here until reset.
- Timing: boot_done (and boot_err) are registered and rise at the same edge that accepts the final byte (or the bad header byte). The last-written word is readable on inst_o in the following cycle.
- Throughput: one byte per cycle sustained. Gaps in ld_valid stall the FSM with no loss of state.
- Reset mid-load: the FSM returns to HDR_HI and the host must resend the full stream. Words already written remain in memory but are not fetchable until a new load completes.
- count==DEPTH is legal and fills the entire memory.

Decomposition:
- Add to defines.v:
  - RstnEnable 1'b0 and RstnDisable 1'b1 (active-low reset levels for this block).
  - Loader FSM state encodings LdHdrHi, LdHdrLo, LdData, LdDone, LdErr (3 bits).
  - InstMemAddrW.
- Reuse the existing InstBus, InstAddrBus, ZeroWord and ChipEnable definitions.
- One sub-module, boot_loader_fsm:
  - Contains the header parse, byte assembly, counters and handshake.
  - Outputs: we, waddr, wdata, ld_ready, boot_done, boot_err.
- inst_rom_boot instantiates boot_loader_fsm and holds the storage array and fetch mux.

Test Plan:
1. Load 2 words: send 00 02 34 01 00 10 34 02 00 20 back-to-back. Required:
   - boot_done rises at the edge of the 10th byte.
   - addr=0, ce=1 -> inst_o=32'h34010010.
   - addr=4 -> 32'h34020020.
   - addr=6 -> 32'h34020020 (low bits ignored).
2. Fetch gating:
   - Before boot_done, any addr with ce=1 -> inst_o=0.
   - After boot_done, ce=0 -> inst_o=0.
   - With ADDR_W=10, addr=32'h1000 returns the same word as addr=0 (wrap).
3. Stalled stream: the scenario 1 bytes with random ld_valid gaps of 0-5 cycles -> identical memory contents. boot_done rises exactly at the edge accepting the final byte. ld_ready drops to 0 the next cycle.
4. Header boundaries:
   - Header 00 00 -> boot_done=1 after the 2nd byte.
   - Header 04 01 (1025 > 1024) -> boot_err=1, ld_ready=0, boot_done stays 0; subsequent bytes ignored.
   - Header 04 00 plus 4096 bytes -> boot_done=1, and the last word is readable at addr=32'hFFC.
5. Reset mid-load:
   - Assert rst=0 for 1 cycle after 5 image bytes -> boot_done=0, ld_ready=1 afterwards.
   - Resend 00 01 DE AD BE EF -> addr=0 reads 32'hDEADBEEF.
   - Asynchronous glitch check: a rst pulse that lies entirely between clock edges has no effect.
6. Post-done traffic: after DONE, drive ld_valid=1 with byte 8'hFF for 10 cycles -> memory unchanged and ld_ready stays 0.
